uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 16x-oversampling UART receiver. Converts the serial line into parallel bytes plus a one-cycle write strobe.
- Sits upstream of the rx FIFO. The FIFO's empty flag and read data feed the ALU interface stage.
- Includes an internal baud-tick generator and a 2-flop input synchronizer.
- Reports framing errors alongside each received byte.

Parameters:
BUS_SIZE, 8, data bits per frame (LSB first) and width of dout
SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit)
DVSR, 326, clock cycles per oversample tick (100 MHz / (19200*16), rounded)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_done_tick  output  1  one-cycle strobe: dout/framing_err valid; drives FIFO write enable
dout  output  BUS_SIZE  last received byte, held until the next rx_done_tick
framing_err  output  1  stop bit sampled low for the byte in dout, held with dout
s_tick  output  1  oversample tick (debug/observability), one clk wide

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - No initial blocks are relied upon.
- Reset values:
  - rx_done_tick=0, dout=0, framing_err=0, s_tick=0.
  - State=IDLE, all counters 0, both sync flops=1.
  - Reset asserted mid-frame aborts the frame with no strobe.
  - Reception restarts on the first falling edge seen after reset is released.
- Synchronizer:
  - rx passes through 2 flops to give rx_s, a 2-cycle delay.
  - All FSM decisions use rx_s only.
- Baud tick:
  - Counter runs 0..DVSR-1 and wraps to 0.
  - s_tick=1 for exactly the one cycle in which the counter equals DVSR-1.
  - Free-running; never resynchronised to the frame.
- FSM states IDLE, START, DATA, STOP. Counters are s_cnt (4 bits) and n_cnt (clog2(BUS_SIZE) bits).
  - IDLE: rx_s==0 -> START, s_cnt=0. This check does not wait for s_tick.
  - START: on s_tick, if s_cnt==7:
    - rx_s==0 -> DATA, s_cnt=0, n_cnt=0.
    - rx_s==1 -> glitch, return to IDLE with no strobe.
    - Otherwise s_cnt++.
  - DATA: on s_tick, if s_cnt==15:
    - s_cnt=0, shift reg = {rx_s, shift[BUS_SIZE-1:1]}.
    - If n_cnt==BUS_SIZE-1 -> STOP, else n_cnt++.
    - Otherwise s_cnt++.
  - STOP: on s_tick, if s_cnt==SB_TICK-1:
    - dout<=shift, framing_err<=~rx_s, rx_done_tick<=1.
    - -> IDLE, s_cnt=0. Otherwise s_cnt++.
- Latency and strobe timing:
  - rx_done_tick is registered. It is high in the cycle after the qualifying s_tick, for exactly 1 cycle.
  - Never high two consecutive cycles.
- Sampling points:
  - Data bits are sampled mid-bit: 8 ticks after the start edge, then every 16 ticks.
  - With SB_TICK=16 the stop bit is sampled mid-bit.
- Framing error:
  - The byte is still delivered and the strobe still fires.
  - framing_err is cleared or set only at the next strobe.
- Line held low (break): after the STOP state the FSM returns to IDLE and immediately restarts. It yields 0x00 frames with framing_err=1 repeatedly; this is the required behaviour.
- Back-to-back frames: a start bit immediately following the stop bit must be accepted with no lost frame.
- Overflow: the FIFO full condition is not observed here. The downstream FIFO owns drop policy.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11).
  - OVERSAMPLE=16 and the mid-bit constant 7.
  - Default BUS_SIZE, SB_TICK, DVSR values, shared with uart_tx.
- Sub-module baud_gen (parameter DVSR; ports clk, reset, tick). The same instance type is reused by uart_tx.

Test Plan (bench overrides DVSR=4 for speed; 1 bit = 64 clks):
- Reset, then send 0xA5 with a valid stop bit. Required:
  - Exactly one rx_done_tick, with dout=0xA5 and framing_err=0.
  - Strobe lands 16 ticks after the last data-bit sample.
- rx low for 4 ticks then high (glitch). Required: no rx_done_tick, FSM back in IDLE, dout unchanged at 0x00.
- Send 0x3C with the stop bit driven 0. Required: rx_done_tick once, dout=0x3C, framing_err=1.
- Then send 0x81 valid. Required: framing_err returns to 0 and dout=0x81.
- Send 0x01 then 0xFF with zero idle gap. Required: two strobes, 0x01 then 0xFF, both framing_err=0.
- Assert reset for 1 cycle mid-DATA of 0x55, then send 0xC3. Required:
  - All outputs 0 the cycle after reset.
  - No strobe for the aborted frame.
  - Single strobe with dout=0xC3.
- Free-run check: s_tick period is exactly DVSR clocks and pulse width is 1 clock, including across a reset release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// default frame/baud parameters used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // 100 MHz clock, 19200 baud, 16x oversampling
  localparam int DEF_BUS_SIZE = 8;
  localparam int DEF_SB_TICK  = 16;
  localparam int DEF_DVSR     = 326;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every DVSR clocks,
// never resynchronised to the serial frame.
module baud_gen
  import uart_pkg::*;
#(
  parameter int DVSR = DEF_DVSR
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(DVSR - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CW'(DVSR - 1));

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 2-flop line synchronizer, start-bit
// qualification, LSB-first data shift and stop-bit framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int DVSR     = DEF_DVSR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic                rx_done_tick,
  output logic [BUS_SIZE-1:0] dout,
  output logic                framing_err,
  output logic                s_tick
);

  localparam int NW = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;

  rx_state_e           state_q;
  logic [3:0]          s_cnt_q;
  logic [NW-1:0]       n_cnt_q;
  logic [BUS_SIZE-1:0] shift_q;
  logic [BUS_SIZE-1:0] dout_q;
  logic                ferr_q;
  logic                done_q;
  logic                rx_meta_q;
  logic                rx_s_q;
  logic                tick_s;

  baud_gen #(.DVSR(DVSR)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_cnt_q   <= 4'd0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;
      case (state_q)
        // Falling edge is acted on immediately; the tick count starts from here.
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_cnt_q <= 4'd0;
          end
        end
        START: begin
          if (tick_s) begin
            if (s_cnt_q == 4'(MID_TICK)) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_cnt_q <= 4'd0;
                n_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
              s_cnt_q <= 4'd0;
              shift_q <= {rx_s_q, shift_q[BUS_SIZE-1:1]};
              if (n_cnt_q == NW'(BUS_SIZE - 1)) begin
                state_q <= STOP;
              end else begin
                n_cnt_q <= n_cnt_q + NW'(1);
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        // Byte is delivered even on a bad stop bit; the error travels with it.
        STOP: begin
          if (tick_s) begin
            if (s_cnt_q == 4'(SB_TICK - 1)) begin
              dout_q  <= shift_q;
              ferr_q  <= ~rx_s_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
              s_cnt_q <= 4'd0;
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          s_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign framing_err  = ferr_q;
  assign s_tick       = tick_s;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, expected bytes
// queued at drive time and matched against strobes captured by a monitor.
module tb_uart_rx;

  localparam int DVSR        = 4;
  localparam int BIT_CLKS    = DVSR * 16;
  localparam int FRAME_TICKS = 8 + 16 * 8 + 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       framing_err;
  logic       s_tick;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0]  d;
    logic        fe;
    int unsigned ticks;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int unsigned tick_total  = 0;
  int unsigned start_ticks = 0;
  int          n_cmp       = 0;
  int          n_err       = 0;

  uart_rx #(.BUS_SIZE(8), .SB_TICK(16), .DVSR(DVSR)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .framing_err  (framing_err),
    .s_tick       (s_tick)
  );

  always #5 clk = ~clk;

  // Capture every strobe with the running tick count at that moment.
  always @(negedge clk) begin
    obs_t o;
    if (rx_done_tick === 1'b1) begin
      o.d     = dout;
      o.fe    = framing_err;
      o.ticks = tick_total;
      obs_q.push_back(o);
    end
    if (s_tick === 1'b1) tick_total++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.d  = b;
    e.fe = ~stop_bit;
    exp_q.push_back(e);
    @(negedge clk);
    rx = 1'b0;
    // rx_s falls two edges later; START counts ticks from the edge after that
    repeat (2) @(negedge clk);
    #1 start_ticks = tick_total;
    repeat (BIT_CLKS - 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (stop_bit) begin
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end else begin
      // Low only past the mid-bit sample, so the tail cannot qualify as a start
      rx = 1'b0;
      repeat (BIT_CLKS / 2 + 8) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS / 2 - 8) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    obs_q.delete();
    exp_q.delete();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({rx_done_tick, dout, framing_err, s_tick} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got done=%b dout=%h ferr=%b tick=%b, want all 0",
               rx_done_tick, dout, framing_err, s_tick);
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (s_tick !== ((i % DVSR) == DVSR - 1)) begin
        n_err++;
        $display("FAIL s_tick_period: cycle %0d after reset got %b, want %b",
                 i, s_tick, ((i % DVSR) == DVSR - 1));
      end
    end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    idle(BIT_CLKS * 2);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_no_strobe: got %0d strobes, want 0", obs_q.size());
    end
    n_cmp++;
    if ({dout, framing_err} !== 9'd0) begin
      n_err++;
      $display("FAIL glitch_dout: got dout=%h ferr=%b, want 00/0", dout, framing_err);
    end
    obs_q.delete();
  endtask

  task automatic test_valid_frame;
    obs_t o;
    exp_t e;
    send_frame(8'hA5, 1'b1);
    idle(BIT_CLKS);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL a5_strobe_count: got %0d, want 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.fe !== e.fe) begin
        n_err++;
        $display("FAIL a5_data: got %h/%b, want %h/%b", o.d, o.fe, e.d, e.fe);
      end
      n_cmp++;
      if (o.ticks - start_ticks != FRAME_TICKS) begin
        n_err++;
        $display("FAIL a5_latency: got %0d ticks, want %0d", o.ticks - start_ticks, FRAME_TICKS);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_framing_error;
    obs_t o;
    exp_t e;
    send_frame(8'h3C, 1'b0);
    idle(BIT_CLKS * 2);
    send_frame(8'h81, 1'b1);
    idle(BIT_CLKS);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_err++;
      $display("FAIL ferr_strobe_count: got %0d, want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.fe !== e.fe) begin
        n_err++;
        $display("FAIL ferr_data: got %h/%b, want %h/%b", o.d, o.fe, e.d, e.fe);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(BIT_CLKS);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_err++;
      $display("FAIL b2b_strobe_count: got %0d, want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.fe !== e.fe) begin
        n_err++;
        $display("FAIL b2b_data: got %h/%b, want %h/%b", o.d, o.fe, e.d, e.fe);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_abort;
    obs_t       o;
    exp_t       e;
    logic [7:0] partial;
    partial = 8'h55;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({rx_done_tick, dout, framing_err, s_tick} !== 11'd0) begin
      n_err++;
      $display("FAIL abort_reset_outputs: got done=%b dout=%h ferr=%b tick=%b, want all 0",
               rx_done_tick, dout, framing_err, s_tick);
    end
    idle(BIT_CLKS * 2);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_no_strobe: got %0d strobes, want 0", obs_q.size());
    end
    obs_q.delete();
    send_frame(8'hC3, 1'b1);
    idle(BIT_CLKS);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL c3_strobe_count: got %0d, want 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.fe !== e.fe) begin
        n_err++;
        $display("FAIL c3_data: got %h/%b, want %h/%b", o.d, o.fe, e.d, e.fe);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_valid_frame();
    test_framing_error();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
